// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: control sequencer for a radix-2 Booth multiply datapath.
// It drives the M/Q/A register enables, selects add or subtract, counts WIDTH
// shift iterations and sequences the product readout (A word, then Q word).
//
// Optional feature macro: BOOTH_CTRL_ZERO_SKIP_EN
//   defined   -> a zero multiplier (q_is_zero in LD_Q) skips straight to readout
//   undefined -> q_is_zero is ignored and every multiply runs WIDTH iterations
//
// Handshake: start is a level request that is only looked at in IDLE. Once a
// run is accepted, busy stays high until DONE has been left, and done pulses
// for exactly one cycle. Any start seen outside IDLE is dropped, not queued.
//
// All outputs are Moore outputs, decoded from the registered state only.
// state_dbg exposes the state register so that checkers can observe it.
module booth_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       q0,
  input  logic       q_m1,
  input  logic       q_is_zero,
  output logic       load_m,
  output logic       load_q,
  output logic       clr_a,
  output logic       load_a,
  output logic       sub_en,
  output logic       shift_r,
  output logic       out_a,
  output logic       out_q,
  output logic       busy,
  output logic       done,
  output logic [3:0] state_dbg
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LD_M   = 4'd1,
    S_LD_Q   = 4'd2,
    S_EXAM   = 4'd3,
    S_ADD    = 4'd4,
    S_SUB    = 4'd5,
    S_SHIFT  = 4'd6,
    S_OUT_HI = 4'd7,
    S_OUT_LO = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             zero_skip;

`ifdef BOOTH_CTRL_ZERO_SKIP_EN
  // A zero multiplier needs no iterations: A is cleared and Q loads zero.
  assign zero_skip = q_is_zero;
`else
  // Feature disabled: the zero flag is deliberately not consumed.
  logic unused_q_is_zero;
  assign unused_q_is_zero = q_is_zero;
  assign zero_skip        = 1'b0;
`endif

  // State register; reset wins over any state, including mid-iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Iteration counter: cleared while loading Q, stepped once per shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == S_LD_Q) begin
      cnt_q <= '0;
    end else if (state_q == S_SHIFT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next-state and Moore output decode; unknown encodings fall back to IDLE
  // with every output low.
  always_comb begin
    state_d = S_IDLE;
    load_m  = 1'b0;
    load_q  = 1'b0;
    clr_a   = 1'b0;
    load_a  = 1'b0;
    sub_en  = 1'b0;
    shift_r = 1'b0;
    out_a   = 1'b0;
    out_q   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = start ? S_LD_M : S_IDLE;
      end
      S_LD_M: begin
        load_m  = 1'b1;
        busy    = 1'b1;
        state_d = S_LD_Q;
      end
      S_LD_Q: begin
        load_q  = 1'b1;
        clr_a   = 1'b1;
        busy    = 1'b1;
        state_d = zero_skip ? S_OUT_HI : S_EXAM;
      end
      S_EXAM: begin
        busy = 1'b1;
        // Booth recoding of the current bit pair {Q0, Q(-1)}.
        case ({q0, q_m1})
          2'b10:   state_d = S_SUB;
          2'b01:   state_d = S_ADD;
          default: state_d = S_SHIFT;
        endcase
      end
      S_ADD: begin
        load_a  = 1'b1;
        busy    = 1'b1;
        state_d = S_SHIFT;
      end
      S_SUB: begin
        load_a  = 1'b1;
        sub_en  = 1'b1;
        busy    = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shift_r = 1'b1;
        busy    = 1'b1;
        // cnt still holds the pre-increment value: LAST_ITER marks shift WIDTH.
        state_d = (cnt_q < LAST_ITER) ? S_EXAM : S_OUT_HI;
      end
      S_OUT_HI: begin
        out_a   = 1'b1;
        busy    = 1'b1;
        state_d = S_OUT_LO;
      end
      S_OUT_LO: begin
        out_q   = 1'b1;
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule
